// File: rtl/sync_debounce_bank.sv
// ---------------------------------------------------------------------------
// sync_debounce_bank
//
// Bank of CHANNELS independent input qualifiers. Each channel passes its
// asynchronous raw input through a SYNC_STAGES-deep synchroniser chain.
// A debounce counter then accepts a level change only after the synchronised
// value has differed from the current level for DEBOUNCE_CYCLES consecutive
// cycles. Each accepted change produces:
//   - a new level_out value,
//   - a one-cycle rise_pulse or fall_pulse,
//   - a sticky event flag that software can clear.
//
// Optional feature: define SYNC_DEBOUNCE_BANK_EVENT_COUNT_EN to add the
// event_count port. It holds an 8-bit saturating counter of accepted edges
// per channel, with channel i in bits [8i+7:8i].
//
// All state resets synchronously on rst (active high).
// ---------------------------------------------------------------------------
module sync_debounce_bank #(
   parameter int CHANNELS        = 4,
   parameter int SYNC_STAGES     = 3,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int RESET_LEVEL     = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CHANNELS-1:0]   in_async,
   input  logic [CHANNELS-1:0]   event_clr,
   output logic [CHANNELS-1:0]   level_out,
   output logic [CHANNELS-1:0]   rise_pulse,
   output logic [CHANNELS-1:0]   fall_pulse,
`ifdef SYNC_DEBOUNCE_BANK_EVENT_COUNT_EN
   output logic [CHANNELS-1:0]   event_sticky,
   output logic [CHANNELS*8-1:0] event_count
`else
   output logic [CHANNELS-1:0]   event_sticky
`endif
);

   // The counter must hold values up to DEBOUNCE_CYCLES-1. Sizing it for
   // DEBOUNCE_CYCLES+1 keeps the width at least 1 when DEBOUNCE_CYCLES is 1.
   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic             RST_BIT  = (RESET_LEVEL != 0);

   (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_chain [CHANNELS];

   logic [CNT_W-1:0]    stable_cnt [CHANNELS];
   logic [CHANNELS-1:0] sync_bit;
   logic [CHANNELS-1:0] mismatch;
   logic [CHANNELS-1:0] accept;

   // Shift each raw input into its own synchroniser chain. Stage 0 samples
   // the pin. No logic sits between stages, so the metastability settling
   // time is not reduced.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            sync_chain[i] <= {SYNC_STAGES{RST_BIT}};
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            sync_chain[i] <= {sync_chain[i][SYNC_STAGES-2:0], in_async[i]};
         end
      end
   end

   // An edge is accepted in the cycle where the counter has already seen
   // DEBOUNCE_CYCLES-1 mismatching cycles and the current cycle still
   // mismatches.
   always_comb begin
      sync_bit = '0;
      mismatch = '0;
      accept   = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         sync_bit[i] = sync_chain[i][SYNC_STAGES-1];
         mismatch[i] = sync_bit[i] ^ level_out[i];
         accept[i]   = mismatch[i] && (stable_cnt[i] == CNT_LAST);
      end
   end

   // Per-channel debounce counter, qualified level and edge pulses.
   // The pulses are registered alongside level_out, so they appear in the
   // same cycle as the new level. Any return to the current level restarts
   // the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         level_out  <= {CHANNELS{RST_BIT}};
         rise_pulse <= '0;
         fall_pulse <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            stable_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            rise_pulse[i] <= 1'b0;
            fall_pulse[i] <= 1'b0;
            if (!mismatch[i]) begin
               stable_cnt[i] <= '0;
            end else if (accept[i]) begin
               level_out[i]  <= sync_bit[i];
               rise_pulse[i] <= sync_bit[i];
               fall_pulse[i] <= ~sync_bit[i];
               stable_cnt[i] <= '0;
            end else begin
               stable_cnt[i] <= stable_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Sticky edge flags. A newly accepted edge overrides a clear request
   // in the same cycle, so software never misses an event that arrives
   // while it is clearing the flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         event_sticky <= '0;
      end else begin
         event_sticky <= accept | (event_sticky & ~event_clr);
      end
   end

`ifdef SYNC_DEBOUNCE_BANK_EVENT_COUNT_EN
   // Saturating per-channel edge counters. An edge that coincides with a
   // clear starts the new count at 1 instead of losing that edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         event_count <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (accept[i]) begin
               if (event_clr[i]) begin
                  event_count[8*i +: 8] <= 8'd1;
               end else if (event_count[8*i +: 8] != 8'hFF) begin
                  event_count[8*i +: 8] <= event_count[8*i +: 8] + 8'd1;
               end
            end else if (event_clr[i]) begin
               event_count[8*i +: 8] <= 8'd0;
            end
         end
      end
   end
`endif

endmodule
